cht_shift_bank: RTL and testbench

//  Registered, parametrised successor of the cht shift/load mux network.

---
 rtl/cht_pkg.sv | 5 +
 rtl/cht_lane.sv | 26 ++
 rtl/cht_shift_bank.sv | 96 +++++++++
 tb/tb_cht_shift_bank.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cht_pkg.sv
// cht_pkg: shared command and FSM state encodings for the cht shift bank.
package cht_pkg;
    typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_SHL, OP_SHR} cht_op_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} cht_state_t;
endpackage

// File: rtl/cht_lane.sv
// cht_lane: one WIDTH-bit lane register with parallel load and 1-bit serial shift.
module cht_lane #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_load,
    input  logic             en_shl,
    input  logic             en_shr,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q, q_d;
    always_comb begin
        q_d = en_load ? load_data
            : en_shl  ? {q_q[WIDTH-2:0], ser_in}
            : en_shr  ? {ser_in, q_q[WIDTH-1:1]}
            : q_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/cht_shift_bank.sv
// cht_shift_bank: bank of lane registers loaded or shifted by valid/ready commands.
module cht_shift_bank
    import cht_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 2,
    parameter int CNT_W = 4,
    parameter int LN_W  = ($clog2(LANES) > 0) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [LN_W-1:0]        cmd_lane,
    input  logic [CNT_W-1:0]       cmd_amt,
    input  logic [WIDTH-1:0]       load_data,
    input  logic                   ser_in,
    output logic [LANES*WIDTH-1:0] q,
    output logic                   busy,
    output logic                   done,
    output logic                   done_err
);
    cht_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LN_W-1:0]  lane_q, lane_d;
    logic             shr_q, shr_d;
    logic             err_q, err_d;
    logic             accept, lane_ok, is_shift;
    cht_op_t          op;

    assign op        = cht_op_t'(cmd_op);
    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign lane_ok   = int'(cmd_lane) < LANES;
    assign is_shift  = (op == OP_SHL) || (op == OP_SHR);

    // Bad lanes and zero-length shifts collapse to a plain NOP completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        shr_d   = shr_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                lane_d  = cmd_lane;
                shr_d   = op == OP_SHR;
                cnt_d   = cmd_amt;
                err_d   = !lane_ok;
                state_d = (lane_ok && is_shift && cmd_amt != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? ST_DONE : ST_SHIFT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lane_q  <= '0;
            shr_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            shr_q   <= shr_d;
            err_q   <= err_d;
        end
    end

    assign busy     = state_q == ST_SHIFT;
    assign done     = state_q == ST_DONE;
    assign done_err = err_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic sel_now, sel_cap;
        assign sel_now = lane_ok && (cmd_lane == LN_W'(g));
        assign sel_cap = busy && (lane_q == LN_W'(g));
        cht_lane #(.WIDTH(WIDTH)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en_load   (accept && op == OP_LOAD && sel_now),
            .en_shl    (sel_cap && !shr_q),
            .en_shr    (sel_cap && shr_q),
            .ser_in    (ser_in),
            .load_data (load_data),
            .q         (q[g*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_cht_shift_bank.sv
// tb_cht_shift_bank: directed vector table plus reset sequences for cht_shift_bank (3 lanes).
module tb_cht_shift_bank;
    logic        clk = 0;
    logic        rst = 1;
    logic        cmd_valid = 0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 0;
    logic [1:0]  cmd_lane = 0;
    logic [3:0]  cmd_amt = 0;
    logic [15:0] load_data = 0;
    logic        ser_in = 0;
    logic [47:0] q;
    logic        busy, done, done_err;
    int          n_cmp = 0;
    int          n_err = 0;

    cht_shift_bank #(.WIDTH(16), .LANES(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_lane(cmd_lane), .cmd_amt(cmd_amt),
        .load_data(load_data), .ser_in(ser_in), .q(q),
        .busy(busy), .done(done), .done_err(done_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  lane;
        logic [3:0]  amt;
        logic [15:0] data;
        logic        ser;
        bit          hold;
        int          lat;
        int          busy_n;
        logic        err;
        logic [15:0] l0, l1, l2;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [1:0] lane, input logic [3:0] amt,
                           input logic [15:0] data, input logic ser, input bit hold,
                           output int lat, output int busy_n, output logic err);
        @(negedge clk);
        cmd_valid = 1; cmd_op = op; cmd_lane = lane; cmd_amt = amt;
        load_data = data; ser_in = ser;
        lat = 0; busy_n = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!hold) cmd_valid = 0;
            if (busy) busy_n++;
        end while (!done && lat < 40);
        err = done_err;
        cmd_valid = 0;
        @(posedge clk); #1;
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("ready_after_done", {63'd0, cmd_ready}, 64'd1);
    endtask

    vec_t v[13];
    int   lat, bn;
    logic err;

    initial begin
        v[0]  = '{2'd1, 2'd1, 4'd0,  16'hA5C3, 1'b0, 1'b0, 1,  0,  1'b0, 16'h0000, 16'hA5C3, 16'h0000};
        v[1]  = '{2'd1, 2'd0, 4'd0,  16'h8001, 1'b0, 1'b0, 1,  0,  1'b0, 16'h8001, 16'hA5C3, 16'h0000};
        v[2]  = '{2'd2, 2'd0, 4'd3,  16'h0000, 1'b1, 1'b0, 4,  3,  1'b0, 16'h000F, 16'hA5C3, 16'h0000};
        v[3]  = '{2'd1, 2'd0, 4'd0,  16'h8001, 1'b0, 1'b0, 1,  0,  1'b0, 16'h8001, 16'hA5C3, 16'h0000};
        v[4]  = '{2'd3, 2'd0, 4'd1,  16'h0000, 1'b0, 1'b0, 2,  1,  1'b0, 16'h4000, 16'hA5C3, 16'h0000};
        v[5]  = '{2'd3, 2'd0, 4'd0,  16'h0000, 1'b1, 1'b0, 1,  0,  1'b0, 16'h4000, 16'hA5C3, 16'h0000};
        v[6]  = '{2'd1, 2'd3, 4'd0,  16'hFFFF, 1'b0, 1'b0, 1,  0,  1'b1, 16'h4000, 16'hA5C3, 16'h0000};
        v[7]  = '{2'd2, 2'd3, 4'd5,  16'h0000, 1'b1, 1'b0, 1,  0,  1'b1, 16'h4000, 16'hA5C3, 16'h0000};
        v[8]  = '{2'd0, 2'd2, 4'd7,  16'h5555, 1'b1, 1'b0, 1,  0,  1'b0, 16'h4000, 16'hA5C3, 16'h0000};
        v[9]  = '{2'd1, 2'd2, 4'd0,  16'h1234, 1'b0, 1'b0, 1,  0,  1'b0, 16'h4000, 16'hA5C3, 16'h1234};
        v[10] = '{2'd3, 2'd2, 4'd15, 16'h0000, 1'b1, 1'b0, 16, 15, 1'b0, 16'h4000, 16'hA5C3, 16'hFFFE};
        v[11] = '{2'd2, 2'd1, 4'd4,  16'h0000, 1'b0, 1'b1, 5,  4,  1'b0, 16'h4000, 16'h5C30, 16'hFFFE};
        v[12] = '{2'd3, 2'd1, 4'd2,  16'h0000, 1'b1, 1'b0, 3,  2,  1'b0, 16'h4000, 16'hD70C, 16'hFFFE};

        // reset held while inputs churn
        repeat (4) begin
            @(negedge clk);
            cmd_valid = 1; cmd_op = 2'($urandom); cmd_lane = 2'($urandom % 3);
            cmd_amt = 4'($urandom); load_data = 16'($urandom); ser_in = 1'($urandom);
        end
        #1;
        chk("rst_q", {16'd0, q}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_ready", {63'd0, cmd_ready}, 64'd0);
        @(negedge clk);
        cmd_valid = 0; rst = 0;
        @(posedge clk); #1;
        chk("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

        for (int i = 0; i < 13; i++) begin
            run_cmd(v[i].op, v[i].lane, v[i].amt, v[i].data, v[i].ser, v[i].hold, lat, bn, err);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(v[i].lat));
            chk($sformatf("v%0d_busy", i), 64'(bn), 64'(v[i].busy_n));
            chk($sformatf("v%0d_err", i), {63'd0, err}, {63'd0, v[i].err});
            chk($sformatf("v%0d_lane0", i), {48'd0, q[15:0]}, {48'd0, v[i].l0});
            chk($sformatf("v%0d_lane1", i), {48'd0, q[31:16]}, {48'd0, v[i].l1});
            chk($sformatf("v%0d_lane2", i), {48'd0, q[47:32]}, {48'd0, v[i].l2});
        end

        // reset lands on the 2nd shift edge of an SHL amt=5
        run_cmd(2'd1, 2'd0, 4'd0, 16'h0001, 1'b0, 1'b0, lat, bn, err);
        @(negedge clk);
        cmd_valid = 1; cmd_op = 2'd2; cmd_lane = 2'd0; cmd_amt = 4'd5; ser_in = 1;
        @(posedge clk); #1;
        cmd_valid = 0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("mid_shift_lane0", {48'd0, q[15:0]}, 64'h0007);
        chk("mid_shift_busy", {63'd0, busy}, 64'd1);
        rst = 1; #1;
        chk("abort_q", {16'd0, q}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_ready", {63'd0, cmd_ready}, 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_done", {63'd0, done}, 64'd0);
        end
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        chk("abort_no_done_after", {63'd0, done}, 64'd0);
        run_cmd(2'd1, 2'd2, 4'd0, 16'h00FF, 1'b0, 1'b0, lat, bn, err);
        chk("post_rst_lat", 64'(lat), 64'd1);
        chk("post_rst_q", {16'd0, q}, {16'd0, 16'h00FF, 16'h0000, 16'h0000});
        run_cmd(2'd2, 2'd2, 4'd2, 16'h0000, 1'b1, 1'b0, lat, bn, err);
        chk("post_rst_shl_lat", 64'(lat), 64'd3);
        chk("post_rst_shl_q", {48'd0, q[47:32]}, 64'h03FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
